// File: rtl/ram_carga_elevador_param.sv
// Elevator cargo queue: compacted slot storage with load/pop, a registered read port
// and an IDLE/UNLOAD FSM that hands out every object addressed to the current floor.
module ram_carga_elevador_param #(
  parameter int DEPTH  = 8,
  parameter int TIPO_W = 2,
  parameter int DEST_W = 2,
  parameter int AW     = $clog2(DEPTH),
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [TIPO_W-1:0] in_tipo_objeto,
  input  logic [DEST_W-1:0] in_destino_objeto,
  input  logic              weT,
  input  logic              shift,
  input  logic              tira_objetos,
  input  logic [DEST_W-1:0] andar_atual,
  input  logic [AW-1:0]     addr,
  output logic [TIPO_W-1:0] tipo_objeto,
  output logic [DEST_W-1:0] destino_objeto,
  output logic              saida_valid,
  input  logic              saida_ready,
  output logic [TIPO_W-1:0] saida_tipo,
  output logic [DEST_W-1:0] saida_destino,
  output logic [CW-1:0]     ocupacao,
  output logic              tem_vaga,
  output logic              vazio,
  output logic              ocupado,
  output logic              erro_cheio
);

  typedef enum logic {IDLE, UNLOAD} state_t;

  state_t              state, state_nxt;
  logic                vld_mem  [DEPTH];
  logic [TIPO_W-1:0]   tipo_mem [DEPTH];
  logic [DEST_W-1:0]   dest_mem [DEPTH];
  logic [CW-1:0]       idx, idx_nxt;
  logic [DEST_W-1:0]   andar_reg, andar_nxt;
  logic [AW-1:0]       addr_reg;
  logic [AW-1:0]       idx_a, tail_a;
  logic                do_load, do_err, do_remove;
  logic [AW-1:0]       rem_pos;
  logic                match, idx_in_range, addr_in_range;

  assign idx_a         = idx[AW-1:0];
  assign tail_a        = ocupacao[AW-1:0];
  assign tem_vaga      = ocupacao < CW'(DEPTH);
  assign vazio         = (ocupacao == '0);
  assign ocupado       = (state == UNLOAD);
  assign idx_in_range  = idx < ocupacao;
  assign match         = idx_in_range && vld_mem[idx_a] && (dest_mem[idx_a] == andar_reg);
  assign saida_valid   = (state == UNLOAD) && match;
  assign saida_tipo    = saida_valid ? tipo_mem[idx_a] : '0;
  assign saida_destino = saida_valid ? dest_mem[idx_a] : '0;

  assign addr_in_range  = CW'(addr_reg) < ocupacao;
  assign tipo_objeto    = addr_in_range ? tipo_mem[addr_reg] : '0;
  assign destino_objeto = addr_in_range ? dest_mem[addr_reg] : '0;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    andar_nxt = andar_reg;
    do_load   = 1'b0;
    do_err    = 1'b0;
    do_remove = 1'b0;
    rem_pos   = '0;
    case (state)
      IDLE: begin
        if (weT) begin
          do_load = tem_vaga;
          do_err  = !tem_vaga;
        end else if (shift) begin
          do_remove = !vazio;
        end else if (tira_objetos) begin
          state_nxt = UNLOAD;
          idx_nxt   = '0;
          andar_nxt = andar_atual;
        end
      end
      UNLOAD: begin
        // A completed handshake keeps idx: the next object slides into the same slot.
        if (!idx_in_range) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (match) begin
          if (saida_ready) begin
            do_remove = 1'b1;
            rem_pos   = idx_a;
          end
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= IDLE;
      idx        <= '0;
      andar_reg  <= '0;
      addr_reg   <= '0;
      ocupacao   <= '0;
      erro_cheio <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      andar_reg  <= andar_nxt;
      addr_reg   <= addr;
      erro_cheio <= do_err;
      if (do_load)
        ocupacao <= ocupacao + 1'b1;
      else if (do_remove)
        ocupacao <= ocupacao - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_mem[i]  <= 1'b0;
        tipo_mem[i] <= '0;
        dest_mem[i] <= '0;
      end
    end else if (do_load) begin
      vld_mem[tail_a]  <= 1'b1;
      tipo_mem[tail_a] <= in_tipo_objeto;
      dest_mem[tail_a] <= in_destino_objeto;
    end else if (do_remove) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (AW'(i) >= rem_pos) begin
          vld_mem[i]  <= vld_mem[i+1];
          tipo_mem[i] <= tipo_mem[i+1];
          dest_mem[i] <= dest_mem[i+1];
        end
      end
      vld_mem[DEPTH-1]  <= 1'b0;
      tipo_mem[DEPTH-1] <= '0;
      dest_mem[DEPTH-1] <= '0;
    end
  end

endmodule

// File: tb/tb_ram_carga_elevador_param.sv
// Directed bench for ram_carga_elevador_param (DEPTH=8, 2-bit type and floor).
module tb_ram_carga_elevador_param;

  localparam int DEPTH = 8;
  localparam int TW = 2;
  localparam int DW = 2;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clear_n;
  logic [TW-1:0] in_tipo_objeto;
  logic [DW-1:0] in_destino_objeto;
  logic          weT, shift, tira_objetos, saida_ready;
  logic [DW-1:0] andar_atual;
  logic [AW-1:0] addr;
  logic [TW-1:0] tipo_objeto, saida_tipo;
  logic [DW-1:0] destino_objeto, saida_destino;
  logic          saida_valid, tem_vaga, vazio, ocupado, erro_cheio;
  logic [CW-1:0] ocupacao;

  int checks = 0;
  int failures = 0;

  ram_carga_elevador_param #(.DEPTH(DEPTH), .TIPO_W(TW), .DEST_W(DW)) dut (
    .clk(clk), .clear_n(clear_n),
    .in_tipo_objeto(in_tipo_objeto), .in_destino_objeto(in_destino_objeto),
    .weT(weT), .shift(shift), .tira_objetos(tira_objetos), .andar_atual(andar_atual),
    .addr(addr), .tipo_objeto(tipo_objeto), .destino_objeto(destino_objeto),
    .saida_valid(saida_valid), .saida_ready(saida_ready),
    .saida_tipo(saida_tipo), .saida_destino(saida_destino),
    .ocupacao(ocupacao), .tem_vaga(tem_vaga), .vazio(vazio),
    .ocupado(ocupado), .erro_cheio(erro_cheio)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    weT = 0; shift = 0; tira_objetos = 0; saida_ready = 0;
    in_tipo_objeto = 0; in_destino_objeto = 0; andar_atual = 0; addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clear_n = 0;
    tick();
    clear_n = 1;
  endtask

  task automatic load(input logic [TW-1:0] t, input logic [DW-1:0] d);
    weT = 1; in_tipo_objeto = t; in_destino_objeto = d;
    tick();
    weT = 0;
  endtask

  task automatic read_slot(input logic [AW-1:0] a, output logic [TW-1:0] t,
                           output logic [DW-1:0] d);
    addr = a;
    tick();
    t = tipo_objeto;
    d = destino_objeto;
  endtask

  task automatic load_floor_queue();
    load(2'd1, 2'd2);
    load(2'd2, 2'd1);
    load(2'd3, 2'd2);
    load(2'd0, 2'd3);
  endtask

  task automatic test_reset();
    idle_inputs();
    clear_n = 0;
    #3;
    checks++;
    if ({tem_vaga, vazio, ocupado, saida_valid, erro_cheio} !== 5'b11000 || ocupacao !== 0 ||
        tipo_objeto !== 0 || destino_objeto !== 0 || saida_tipo !== 0 || saida_destino !== 0) begin
      failures++;
      $display("FAIL reset_outputs: flags=%b ocupacao=%0d data=%0d/%0d/%0d/%0d required flags=11000 rest 0",
               {tem_vaga, vazio, ocupado, saida_valid, erro_cheio}, ocupacao,
               tipo_objeto, destino_objeto, saida_tipo, saida_destino);
    end
    tick();
    clear_n = 1;
  endtask

  task automatic test_load_read();
    logic [TW-1:0] t;
    logic [DW-1:0] d;
    do_reset();
    load(2'd1, 2'd2);
    load(2'd3, 2'd0);
    load(2'd0, 2'd0);
    checks++;
    if (ocupacao !== 3 || vazio !== 0) begin
      failures++;
      $display("FAIL load3_count: ocupacao=%0d vazio=%b required 3/0", ocupacao, vazio);
    end
    read_slot(3'd2, t, d);
    checks++;
    if (t !== 0 || d !== 0) begin
      failures++;
      $display("FAIL read_slot2: got %0d/%0d required 0/0", t, d);
    end
    read_slot(3'd0, t, d);
    checks++;
    if (t !== 1 || d !== 2) begin
      failures++;
      $display("FAIL read_slot0: got %0d/%0d required 1/2", t, d);
    end
    read_slot(3'd1, t, d);
    checks++;
    if (t !== 3 || d !== 0) begin
      failures++;
      $display("FAIL read_slot1: got %0d/%0d required 3/0", t, d);
    end
    read_slot(3'd5, t, d);
    checks++;
    if (t !== 0 || d !== 0) begin
      failures++;
      $display("FAIL read_beyond: got %0d/%0d required 0/0", t, d);
    end
  endtask

  task automatic test_full();
    logic [TW-1:0] t;
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < DEPTH; i++) load(TW'(i), DW'(i + 1));
    checks++;
    if (ocupacao !== 8 || tem_vaga !== 0 || erro_cheio !== 0) begin
      failures++;
      $display("FAIL full_flags: ocupacao=%0d tem_vaga=%b erro=%b required 8/0/0",
               ocupacao, tem_vaga, erro_cheio);
    end
    load(2'd2, 2'd2);
    checks++;
    if (erro_cheio !== 1 || ocupacao !== 8) begin
      failures++;
      $display("FAIL overflow_pulse: erro=%b ocupacao=%0d required 1/8", erro_cheio, ocupacao);
    end
    tick();
    checks++;
    if (erro_cheio !== 0) begin
      failures++;
      $display("FAIL overflow_pulse_len: erro=%b required 0", erro_cheio);
    end
    read_slot(3'd7, t, d);
    checks++;
    if (t !== 3 || d !== 0) begin
      failures++;
      $display("FAIL full_slot7: got %0d/%0d required 3/0", t, d);
    end
  endtask

  task automatic test_unload();
    logic [TW-1:0] t;
    logic [DW-1:0] d;
    int n_xfer;
    logic [TW-1:0] xt [2];
    logic [DW-1:0] xd [2];
    int guard;
    do_reset();
    load_floor_queue();
    andar_atual = 2; saida_ready = 1; tira_objetos = 1;
    tick();
    tira_objetos = 0;
    checks++;
    if (ocupado !== 1 || saida_valid !== 1 || saida_tipo !== 1 || saida_destino !== 2) begin
      failures++;
      $display("FAIL unload_first: ocupado=%b valid=%b data=%0d/%0d required 1/1 1/2",
               ocupado, saida_valid, saida_tipo, saida_destino);
    end
    n_xfer = 0;
    guard = 0;
    while (ocupado && guard < 20) begin
      if (saida_valid && saida_ready) begin
        if (n_xfer < 2) begin
          xt[n_xfer] = saida_tipo;
          xd[n_xfer] = saida_destino;
        end
        n_xfer++;
      end
      tick();
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      failures++;
      $display("FAIL unload_timeout: ocupado=%b after %0d cycles required 0", ocupado, guard);
    end
    checks++;
    if (n_xfer !== 2 || xt[0] !== 1 || xd[0] !== 2 || xt[1] !== 3 || xd[1] !== 2) begin
      failures++;
      $display("FAIL unload_xfers: n=%0d %0d/%0d %0d/%0d required 2 1/2 3/2",
               n_xfer, xt[0], xd[0], xt[1], xd[1]);
    end
    saida_ready = 0;
    checks++;
    if (ocupacao !== 2 || ocupado !== 0 || saida_valid !== 0) begin
      failures++;
      $display("FAIL unload_end: ocupacao=%0d ocupado=%b valid=%b required 2/0/0",
               ocupacao, ocupado, saida_valid);
    end
    read_slot(3'd0, t, d);
    checks++;
    if (t !== 2 || d !== 1) begin
      failures++;
      $display("FAIL unload_rest0: got %0d/%0d required 2/1", t, d);
    end
    read_slot(3'd1, t, d);
    checks++;
    if (t !== 0 || d !== 3) begin
      failures++;
      $display("FAIL unload_rest1: got %0d/%0d required 0/3", t, d);
    end
  endtask

  task automatic test_stall();
    int guard;
    do_reset();
    load_floor_queue();
    andar_atual = 2; saida_ready = 0; tira_objetos = 1;
    tick();
    tira_objetos = 0;
    // Loads and pops must be ignored while unloading.
    weT = 1; shift = 1; in_tipo_objeto = 3; in_destino_objeto = 3;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (saida_valid !== 1 || saida_tipo !== 1 || saida_destino !== 2 ||
          ocupacao !== 4 || erro_cheio !== 0) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b data=%0d/%0d ocupacao=%0d erro=%b required 1 1/2 4 0",
                 c, saida_valid, saida_tipo, saida_destino, ocupacao, erro_cheio);
      end
    end
    weT = 0; shift = 0;
    saida_ready = 1;
    tick();
    checks++;
    if (ocupacao !== 3) begin
      failures++;
      $display("FAIL stall_release: ocupacao=%0d required 3", ocupacao);
    end
    guard = 0;
    while (ocupado && guard < 20) begin
      tick();
      guard++;
    end
    saida_ready = 0;
    checks++;
    if (ocupado !== 0 || ocupacao !== 2) begin
      failures++;
      $display("FAIL stall_end: ocupado=%b ocupacao=%0d required 0/2", ocupado, ocupacao);
    end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] t;
    logic [DW-1:0] d;
    do_reset();
    load(2'd1, 2'd1);
    load(2'd2, 2'd2);
    weT = 1; shift = 1; in_tipo_objeto = 3; in_destino_objeto = 3;
    tick();
    weT = 0; shift = 0;
    checks++;
    if (ocupacao !== 3) begin
      failures++;
      $display("FAIL b2b_count: ocupacao=%0d required 3", ocupacao);
    end
    read_slot(3'd0, t, d);
    checks++;
    if (t !== 1 || d !== 1) begin
      failures++;
      $display("FAIL b2b_head: got %0d/%0d required 1/1", t, d);
    end
    read_slot(3'd2, t, d);
    checks++;
    if (t !== 3 || d !== 3) begin
      failures++;
      $display("FAIL b2b_tail: got %0d/%0d required 3/3", t, d);
    end
    shift = 1;
    tick();
    shift = 0;
    checks++;
    if (ocupacao !== 2) begin
      failures++;
      $display("FAIL pop_count: ocupacao=%0d required 2", ocupacao);
    end
    read_slot(3'd0, t, d);
    checks++;
    if (t !== 2 || d !== 2) begin
      failures++;
      $display("FAIL pop_head: got %0d/%0d required 2/2", t, d);
    end
    read_slot(3'd1, t, d);
    checks++;
    if (t !== 3 || d !== 3) begin
      failures++;
      $display("FAIL pop_next: got %0d/%0d required 3/3", t, d);
    end
  endtask

  task automatic test_reset_mid_unload();
    do_reset();
    load_floor_queue();
    andar_atual = 2; saida_ready = 0; tira_objetos = 1;
    tick();
    tira_objetos = 0;
    checks++;
    if (saida_valid !== 1) begin
      failures++;
      $display("FAIL midreset_pre: valid=%b required 1", saida_valid);
    end
    #1 clear_n = 0;
    #1;
    checks++;
    if (ocupacao !== 0 || ocupado !== 0 || saida_valid !== 0 || saida_tipo !== 0 || vazio !== 1) begin
      failures++;
      $display("FAIL midreset_async: ocupacao=%0d ocupado=%b valid=%b tipo=%0d vazio=%b required 0/0/0/0/1",
               ocupacao, ocupado, saida_valid, saida_tipo, vazio);
    end
    #1 clear_n = 1;
    tick();
    checks++;
    if (ocupado !== 0 || ocupacao !== 0) begin
      failures++;
      $display("FAIL midreset_after: ocupado=%b ocupacao=%0d required 0/0", ocupado, ocupacao);
    end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_full();
    test_unload();
    test_stall();
    test_back_to_back();
    test_reset_mid_unload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
